// File: rtl/clock_rst_sequencer.sv
// Reset sequencer: pulses the PLL reset, waits for lock, then releases CHANNELS resets in order.
// Optional status counters are enabled with `define CLOCK_RST_SEQUENCER_STATUS_EN.
module clock_rst_sequencer #(
    parameter int unsigned CHANNELS       = 4,
    parameter int unsigned STAGE_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT   = 65536,
    parameter int unsigned PLL_RST_CYCLES = 8,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_locked,
    output logic                o_pll_rst,
    output logic [CHANNELS-1:0] o_rst,
`ifdef CLOCK_RST_SEQUENCER_STATUS_EN
    output logic [7:0]          o_lock_losses,
    output logic [7:0]          o_timeouts,
`endif
    output logic                o_ready
);

    localparam int unsigned MaxA   = (STAGE_CYCLES > PLL_RST_CYCLES) ? STAGE_CYCLES
                                                                     : PLL_RST_CYCLES;
    localparam int unsigned CntMax = (LOCK_TIMEOUT > MaxA) ? LOCK_TIMEOUT : MaxA;
    localparam int unsigned CntW   = $clog2(CntMax) + 1;

    typedef enum logic [1:0] {StPllRst, StWaitLock, StRelease, StRun} state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [CHANNELS-1:0]    rst_q, rst_d;
    logic                   pll_rst_q, pll_rst_d;
    logic                   ready_q, ready_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   locked_s;
    logic                   lock_loss;
    logic                   timeout;

    assign sync_d   = {sync_q[SYNC_STAGES-2:0], i_locked};
    assign locked_s = sync_q[SYNC_STAGES-1];

    assign lock_loss = ((state_q == StRelease) || (state_q == StRun)) && !locked_s;
    assign timeout   = (state_q == StWaitLock) && !locked_s &&
                       (cnt_q == CntW'(LOCK_TIMEOUT - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= StPllRst;
            cnt_q     <= '0;
            rst_q     <= '1;
            pll_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            sync_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rst_q     <= rst_d;
            pll_rst_q <= pll_rst_d;
            ready_q   <= ready_d;
            sync_q    <= sync_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rst_d   = rst_q;
        unique case (state_q)
            StPllRst: begin
                rst_d = '1;
                if (cnt_q == CntW'(PLL_RST_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = StWaitLock;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitLock: begin
                rst_d = '1;
                if (locked_s) begin
                    cnt_d   = '0;
                    state_d = StRelease;
                end else if (timeout) begin
                    cnt_d   = '0;
                    state_d = StPllRst;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRelease: begin
                // Lock loss wins over a release due in the same cycle.
                if (lock_loss) begin
                    cnt_d   = '0;
                    rst_d   = '1;
                    state_d = StPllRst;
                end else if (cnt_q == CntW'(STAGE_CYCLES - 1)) begin
                    cnt_d = '0;
                    rst_d = rst_q & (rst_q - CHANNELS'(1));
                    if (rst_d == '0) begin
                        state_d = StRun;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (lock_loss) begin
                    cnt_d   = '0;
                    rst_d   = '1;
                    state_d = StPllRst;
                end
            end
            default: begin
                cnt_d   = '0;
                rst_d   = '1;
                state_d = StPllRst;
            end
        endcase
    end

    always_comb begin
        pll_rst_d = (state_d == StPllRst);
        ready_d   = (state_d == StRun);
    end

    assign o_pll_rst = pll_rst_q;
    assign o_rst     = rst_q;
    assign o_ready   = ready_q;

`ifdef CLOCK_RST_SEQUENCER_STATUS_EN
    logic [7:0] losses_q, losses_d;
    logic [7:0] timeouts_q, timeouts_d;

    always_comb begin
        losses_d   = losses_q;
        timeouts_d = timeouts_q;
        if (lock_loss && (losses_q != 8'hFF)) begin
            losses_d = losses_q + 8'd1;
        end
        if (timeout && (timeouts_q != 8'hFF)) begin
            timeouts_d = timeouts_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            losses_q   <= '0;
            timeouts_q <= '0;
        end else begin
            losses_q   <= losses_d;
            timeouts_q <= timeouts_d;
        end
    end

    assign o_lock_losses = losses_q;
    assign o_timeouts    = timeouts_q;
`endif

endmodule

// File: tb/tb_clock_rst_sequencer.sv
// Directed bench for clock_rst_sequencer: vector table plus hand-written corner sequences.
// Status-counter checks compile in when CLOCK_RST_SEQUENCER_STATUS_EN is defined.
module tb_clock_rst_sequencer;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_locked;
    logic       o_pll_rst;
    logic [3:0] o_rst;
    logic       o_ready;
`ifdef CLOCK_RST_SEQUENCER_STATUS_EN
    logic [7:0] o_lock_losses;
    logic [7:0] o_timeouts;
`endif

    int n;
    int checks = 0;
    int fails  = 0;

    clock_rst_sequencer #(
        .CHANNELS      (4),
        .STAGE_CYCLES  (16),
        .LOCK_TIMEOUT  (32),
        .PLL_RST_CYCLES(8),
        .SYNC_STAGES   (2)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_locked     (i_locked),
        .o_pll_rst    (o_pll_rst),
        .o_rst        (o_rst),
`ifdef CLOCK_RST_SEQUENCER_STATUS_EN
        .o_lock_losses(o_lock_losses),
        .o_timeouts   (o_timeouts),
`endif
        .o_ready      (o_ready)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        bit         do_rst;
        bit         lk;
        int         n;
        logic [3:0] rst_exp;
        logic       pll_exp;
        logic       rdy_exp;
    } vec_t;

    vec_t tbl [19];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at n=%0d: got %0h, expected %0h", name, n, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge i_clk);
        n++;
        @(negedge i_clk);
    endtask

    task automatic go_to(input int target);
        while (n < target) step();
    endtask

    task automatic apply_reset(input logic lk);
        i_rst_n  = 1'b0;
        i_locked = lk;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        n       = 0;
    endtask

    task automatic check_outs(input string tag, input logic [3:0] r, input logic p,
                              input logic y);
        check({tag, " o_rst"}, 16'(o_rst), 16'(r));
        check({tag, " o_pll_rst"}, 16'(o_pll_rst), 16'(p));
        check({tag, " o_ready"}, 16'(o_ready), 16'(y));
    endtask

    task automatic apply_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (tbl[i].do_rst) apply_reset(tbl[i].lk);
            else i_locked = tbl[i].lk;
            go_to(tbl[i].n);
            check_outs($sformatf("vec%0d", i), tbl[i].rst_exp, tbl[i].pll_exp, tbl[i].rdy_exp);
        end
    endtask

    initial begin
        // Locked throughout: PLL reset 8 cycles, RELEASE entered at n=9.
        tbl[0]  = '{1'b1, 1'b1, 0,  4'hF, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 7,  4'hF, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 8,  4'hF, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 24, 4'hF, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 25, 4'hE, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 40, 4'hE, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 41, 4'hC, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 56, 4'hC, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 57, 4'h8, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 72, 4'h8, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 73, 4'h0, 1'b0, 1'b1};
        // Never locked: 8 cycles PLL reset then 32 cycles waiting, period 40.
        tbl[11] = '{1'b1, 1'b0, 0,  4'hF, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 8,  4'hF, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 39, 4'hF, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 40, 4'hF, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 47, 4'hF, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 48, 4'hF, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 79, 4'hF, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 80, 4'hF, 1'b1, 1'b0};

        i_rst_n  = 1'b0;
        i_locked = 1'b1;
        n        = 0;
        @(negedge i_clk);

        apply_range(0, 10);

        // Lock drops for 5 cycles in RUN; FSM reacts on the third edge.
        go_to(80);
        i_locked = 1'b0;
        go_to(82);
        check_outs("run_loss_pre", 4'h0, 1'b0, 1'b1);
        step();
        check_outs("run_loss", 4'hF, 1'b1, 1'b0);
`ifdef CLOCK_RST_SEQUENCER_STATUS_EN
        check("lock_losses_run", 16'(o_lock_losses), 16'd1);
`endif
        go_to(85);
        i_locked = 1'b1;
        go_to(90);
        check_outs("reseq_pll_hi", 4'hF, 1'b1, 1'b0);
        step();
        check_outs("reseq_pll_lo", 4'hF, 1'b0, 1'b0);
        go_to(108);
        check_outs("reseq_ch0", 4'hE, 1'b0, 1'b0);
        go_to(155);
        check_outs("reseq_ch3_pre", 4'h8, 1'b0, 1'b0);
        step();
        check_outs("reseq_done", 4'h0, 1'b0, 1'b1);

        apply_range(11, 18);
`ifdef CLOCK_RST_SEQUENCER_STATUS_EN
        check("timeouts_2", 16'(o_timeouts), 16'd2);
        go_to(10200);
        check("timeouts_sat", 16'(o_timeouts), 16'd255);
        go_to(10280);
        check("timeouts_hold", 16'(o_timeouts), 16'd255);
`endif

        // One-cycle lock glitch during WAIT_LOCK reaches locked_s.
        apply_reset(1'b0);
        go_to(10);
        i_locked = 1'b1;
        step();
        i_locked = 1'b0;
        go_to(13);
        check_outs("glitch_release", 4'hF, 1'b0, 1'b0);
        step();
        check_outs("glitch_loss", 4'hF, 1'b1, 1'b0);

        // Lock loss lands on the channel-2 release edge (n=57).
        apply_reset(1'b1);
        go_to(54);
        i_locked = 1'b0;
        go_to(56);
        check_outs("ch2_loss_pre", 4'hC, 1'b0, 1'b0);
        step();
        check_outs("ch2_loss", 4'hF, 1'b1, 1'b0);
`ifdef CLOCK_RST_SEQUENCER_STATUS_EN
        check("lock_losses_ch2", 16'(o_lock_losses), 16'd1);
`endif

        // Asynchronous reset between channel 1 and channel 2 release.
        apply_reset(1'b1);
        go_to(45);
        check_outs("mid_rst_pre", 4'hC, 1'b0, 1'b0);
        i_rst_n = 1'b0;
        #1;
        check_outs("mid_rst_async", 4'hF, 1'b1, 1'b0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
